// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment display path: segment patterns (g..a,
// active-low), digit count, and the anode select helper.
package seven_seg_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);
  localparam int unsigned FRAME_W    = NUM_DIGITS * NIB_W;

  localparam logic [SEG_W-1:0] SEG_0 = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h10;
  localparam logic [SEG_W-1:0] SEG_A = 7'h08;
  localparam logic [SEG_W-1:0] SEG_B = 7'h03;
  localparam logic [SEG_W-1:0] SEG_C = 7'h46;
  localparam logic [SEG_W-1:0] SEG_D = 7'h21;
  localparam logic [SEG_W-1:0] SEG_E = 7'h06;
  localparam logic [SEG_W-1:0] SEG_F = 7'h0E;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } an_sel_t;

  // Anode select is usable only when exactly one active-low line is asserted.
  function automatic an_sel_t onehot_low_idx(input logic [NUM_DIGITS-1:0] an);
    an_sel_t     r;
    int unsigned zeros;
    r     = '0;
    zeros = 0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (!an[i]) begin
        zeros++;
        r.idx = IDX_W'(i);
      end
    end
    r.valid = (zeros == 1);
    return r;
  endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Segment pattern back to hex nibble; anything outside the encoder's code set
// is flagged illegal and reads as zero.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [SEG_W-1:0] seg_i,
  output logic [NIB_W-1:0] nibble_c_o,
  output logic             illegal_c_o
);

  always_comb begin
    nibble_c_o  = '0;
    illegal_c_o = 1'b0;
    case (seg_i)
      SEG_0:   nibble_c_o = 4'h0;
      SEG_1:   nibble_c_o = 4'h1;
      SEG_2:   nibble_c_o = 4'h2;
      SEG_3:   nibble_c_o = 4'h3;
      SEG_4:   nibble_c_o = 4'h4;
      SEG_5:   nibble_c_o = 4'h5;
      SEG_6:   nibble_c_o = 4'h6;
      SEG_7:   nibble_c_o = 4'h7;
      SEG_8:   nibble_c_o = 4'h8;
      SEG_9:   nibble_c_o = 4'h9;
      SEG_A:   nibble_c_o = 4'hA;
      SEG_B:   nibble_c_o = 4'hB;
      SEG_C:   nibble_c_o = 4'hC;
      SEG_D:   nibble_c_o = 4'hD;
      SEG_E:   nibble_c_o = 4'hE;
      SEG_F:   nibble_c_o = 4'hF;
      default: illegal_c_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Receiver for the multiplexed 4-digit seven-segment bus: debounces each digit,
// assembles a frame and offers it on a valid/ready handshake.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            seg,
  input  logic [NUM_DIGITS-1:0] an,
  output logic [FRAME_W-1:0]    out_value,
  output logic                  out_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow
);

  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SEG_W-1:0]      prev_seg_q;
  logic [NUM_DIGITS-1:0] prev_an_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_d;
  logic [NUM_DIGITS-1:0] bad_q, bad_d;
  logic [FRAME_W-1:0]    slots_q, slots_d;
  logic [FRAME_W-1:0]    value_q, value_d;
  logic                  err_q, err_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;

  an_sel_t          sel_c;
  logic             same_c;
  logic             capture_c;
  logic             complete_c;
  logic [NIB_W-1:0] nibble_c;
  logic             illegal_c;
  logic             unused_dp;

  assign unused_dp = seg[7];
  assign sel_c     = onehot_low_idx(an);

  seven_seg_decode u_decode (
    .seg_i       (seg[SEG_W-1:0]),
    .nibble_c_o  (nibble_c),
    .illegal_c_o (illegal_c)
  );

  always_comb begin
    same_c     = (seg[SEG_W-1:0] == prev_seg_q) && (an == prev_an_q);
    cnt_d      = '0;
    mask_d     = mask_q;
    bad_d      = bad_q;
    slots_d    = slots_q;
    value_d    = value_q;
    err_d      = err_q;
    valid_d    = valid_q;
    ovf_d      = ovf_q;
    complete_c = (mask_q == '1);

    if (sel_c.valid && same_c) begin
      cnt_d = (cnt_q >= CNT_SAT) ? CNT_SAT : cnt_q + CNT_W'(1);
    end
    // Fire once per dwell: only on the transition into the last count.
    capture_c = sel_c.valid && (cnt_d == CNT_LAST) && (!same_c || (cnt_q != CNT_LAST));

    if (complete_c) begin
      mask_d = '0;
      bad_d  = '0;
      if (!valid_q || out_ready) begin
        value_d = slots_q;
        err_d   = |bad_q;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    // A capture alongside completion lands in the next frame.
    if (capture_c) begin
      slots_d[NIB_W*sel_c.idx +: NIB_W] = nibble_c;
      bad_d[sel_c.idx]                  = illegal_c;
      mask_d[sel_c.idx]                 = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_seg_q <= '0;
      prev_an_q  <= '0;
      cnt_q      <= '0;
      mask_q     <= '0;
      bad_q      <= '0;
      slots_q    <= '0;
      value_q    <= '0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      prev_seg_q <= seg[SEG_W-1:0];
      prev_an_q  <= an;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      bad_q      <= bad_d;
      slots_q    <= slots_d;
      value_q    <= value_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_value = value_q;
  assign out_err   = err_q;
  assign out_valid = valid_q;
  assign overflow  = ovf_q;

endmodule
